// File: rtl/usb3_buf_pkg.sv
// Shared types and length arithmetic for the USB3 endpoint IN buffer streamer.
package usb3_buf_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    COMMIT,
    WAIT_FREE
  } buf_in_state_t;

  localparam int unsigned BYTES_PER_WORD = 4;

  function automatic int unsigned calc_len(input int unsigned words, input int unsigned tail_bytes);
    return words * BYTES_PER_WORD + tail_bytes;
  endfunction

endpackage

// File: rtl/usb3_buf_in_streamer_if.sv
// Endpoint IN buffer bus between the streamer (master) and the USB3 core (slave).
interface usb3_buf_in_streamer_if #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned LEN_WIDTH  = 11
);
  logic                  buf_in_ready;
  logic [ADDR_WIDTH-1:0] buf_in_addr;
  logic [31:0]           buf_in_data;
  logic                  buf_in_wren;
  logic                  buf_in_commit;
  logic [LEN_WIDTH-1:0]  buf_in_commit_len;
  logic                  buf_in_commit_ack;

  modport master (
    input  buf_in_ready, buf_in_commit_ack,
    output buf_in_addr, buf_in_data, buf_in_wren, buf_in_commit, buf_in_commit_len
  );

  modport slave (
    output buf_in_ready, buf_in_commit_ack,
    input  buf_in_addr, buf_in_data, buf_in_wren, buf_in_commit, buf_in_commit_len
  );
endinterface

// File: rtl/usb3_idle_timer.sv
// Idle down-counter: reloads on clear, counts enabled cycles, pulses expire on the last one.
module usb3_idle_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expire
);
  localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= LOAD;
    end else if (en && cnt != '0) begin
      cnt <= cnt - ONE;
    end
  end

  // A zero timeout leaves the counter parked at 0, so expire can never assert.
  assign expire = (TIMEOUT_CYCLES != 0) && en && (cnt == ONE);
endmodule

// File: rtl/usb3_buf_in_streamer.sv
// Writes a 32-bit valid/ready stream into the USB3 endpoint IN buffer and commits packets.
module usb3_buf_in_streamer
  import usb3_buf_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 9,
  parameter int unsigned MAX_PKT_WORDS  = 256,
  parameter int unsigned LEN_WIDTH      = 11,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        ext_clk,
  input  logic        reset,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  input  logic        s_last,
  input  logic [2:0]  s_last_bytes,
  output logic        s_ready,
  usb3_buf_in_streamer_if.master buf_in,
  output logic [15:0] pkt_count,
  output logic        busy
);
  if (MAX_PKT_WORDS * BYTES_PER_WORD >= 2 ** LEN_WIDTH) begin : g_len_chk
    $error("MAX_PKT_WORDS*4 does not fit in LEN_WIDTH bits");
  end
  if (MAX_PKT_WORDS == 0 || MAX_PKT_WORDS > 2 ** ADDR_WIDTH) begin : g_addr_chk
    $error("MAX_PKT_WORDS must be in 1..2**ADDR_WIDTH");
  end

  localparam logic [ADDR_WIDTH:0]  MAX_W    = (ADDR_WIDTH + 1)'(MAX_PKT_WORDS);
  localparam logic [LEN_WIDTH-1:0] FULL_LEN = LEN_WIDTH'(MAX_PKT_WORDS * BYTES_PER_WORD);

  buf_in_state_t         state;
  logic [ADDR_WIDTH-1:0] wcnt;
  logic [ADDR_WIDTH:0]   wnext;
  logic                  wf_wait;
  logic                  accept;
  logic                  tmr_clear;
  logic                  tmr_en;
  logic                  tmr_expire;

  assign s_ready   = (state == FILL);
  assign busy      = (state != IDLE);
  assign accept    = s_valid && s_ready;
  assign wnext     = {1'b0, wcnt} + 1'b1;
  assign tmr_clear = (state != FILL) || accept;
  // Timer only runs on idle cycles with data pending, so an accepted word always beats expiry.
  assign tmr_en    = (state == FILL) && (wcnt != '0) && !accept;

  usb3_idle_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_idle_timer (
    .clk    (ext_clk),
    .reset  (reset),
    .clear  (tmr_clear),
    .en     (tmr_en),
    .expire (tmr_expire)
  );

  always_ff @(posedge ext_clk) begin
    if (reset) begin
      state                    <= IDLE;
      wcnt                     <= '0;
      wf_wait                  <= 1'b0;
      buf_in.buf_in_addr       <= '0;
      buf_in.buf_in_data       <= '0;
      buf_in.buf_in_wren       <= 1'b0;
      buf_in.buf_in_commit     <= 1'b0;
      buf_in.buf_in_commit_len <= '0;
      pkt_count                <= '0;
    end else begin
      buf_in.buf_in_wren <= 1'b0;
      unique case (state)
        IDLE: begin
          if (buf_in.buf_in_ready) begin
            state <= FILL;
            wcnt  <= '0;
          end
        end
        FILL: begin
          if (accept) begin
            buf_in.buf_in_wren <= 1'b1;
            buf_in.buf_in_addr <= wcnt;
            buf_in.buf_in_data <= s_data;
            wcnt               <= wnext[ADDR_WIDTH-1:0];
            if (s_last) begin
              buf_in.buf_in_commit_len <= LEN_WIDTH'(calc_len(32'(wcnt), 32'(s_last_bytes)));
              state                    <= COMMIT;
            end else if (wnext == MAX_W) begin
              buf_in.buf_in_commit_len <= FULL_LEN;
              state                    <= COMMIT;
            end
          end else if (tmr_expire) begin
            // No write is in flight on a timeout, so the commit can rise straight away.
            buf_in.buf_in_commit_len <= LEN_WIDTH'(calc_len(32'(wcnt), 0));
            buf_in.buf_in_commit     <= 1'b1;
            state                    <= COMMIT;
          end
        end
        COMMIT: begin
          if (buf_in.buf_in_commit && buf_in.buf_in_commit_ack) begin
            buf_in.buf_in_commit <= 1'b0;
            pkt_count            <= pkt_count + 16'd1;
            wf_wait              <= 1'b0;
            state                <= WAIT_FREE;
          end else begin
            buf_in.buf_in_commit <= 1'b1;
          end
        end
        WAIT_FREE: begin
          if (!buf_in.buf_in_ready || wf_wait) begin
            state <= IDLE;
          end else begin
            wf_wait <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_usb3_buf_in_streamer.sv
// Randomized self-checking bench for usb3_buf_in_streamer with a packet-level reference model.
module tb_usb3_buf_in_streamer;
  localparam int PERIOD  = 10;
  localparam int TIMEOUT = 16;
  localparam int MAXW    = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_last;
  logic [2:0]  s_last_bytes;
  logic        s_ready;
  logic [15:0] pkt_count;
  logic        busy;

  usb3_buf_in_streamer_if #(.ADDR_WIDTH(9), .LEN_WIDTH(11)) bus ();

  usb3_buf_in_streamer #(
    .ADDR_WIDTH     (9),
    .MAX_PKT_WORDS  (MAXW),
    .LEN_WIDTH      (11),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .ext_clk      (clk),
    .reset        (reset),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_last       (s_last),
    .s_last_bytes (s_last_bytes),
    .s_ready      (s_ready),
    .buf_in       (bus),
    .pkt_count    (pkt_count),
    .busy         (busy)
  );

  always #(PERIOD / 2) clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_pkts = 0;

  // Observed bus activity, recorded away from the active edge.
  int unsigned wa_q[$];
  logic [31:0] wd_q[$];
  int          commit_rises = 0;
  int          overlap = 0;
  time         commit_t = 0;
  logic [10:0] commit_len_seen = '0;
  logic        prev_commit = 1'b0;

  always @(negedge clk) begin
    if (bus.buf_in_wren === 1'b1) begin
      wa_q.push_back(int'(bus.buf_in_addr));
      wd_q.push_back(bus.buf_in_data);
    end
    if (bus.buf_in_wren === 1'b1 && bus.buf_in_commit === 1'b1) overlap++;
    if (bus.buf_in_commit === 1'b1 && prev_commit !== 1'b1) begin
      commit_rises++;
      commit_t        = $time;
      commit_len_seen = bus.buf_in_commit_len;
    end
    prev_commit = bus.buf_in_commit;
  end

  // Reference model: words the bench expects written for the current packet, addr = index.
  logic [31:0] exp_d[$];

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] lb,
                           output time t_acc, output bit ok);
    int   n = 0;
    logic acc;
    ok = 0;
    t_acc = 0;
    s_data = d; s_last = last; s_last_bytes = lb; s_valid = 1'b1;
    while (n < 200 && !ok) begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      t_acc = $time;
      #1;
      if (acc === 1'b1) ok = 1;
      n++;
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  // Streams n words (index data or random), optional s_last on the final word; extends exp_d.
  task automatic send_pkt(input int n, input bit use_last, input logic [2:0] lb, input int gap_max,
                          input bit idx_data, output time t_last, output bit all_ok);
    bit          ok;
    logic [31:0] d;
    all_ok = 1;
    t_last = 0;
    for (int i = 0; i < n; i++) begin
      if (gap_max > 0) idle($urandom_range(0, gap_max));
      d = idx_data ? 32'(i) : $urandom();
      send_word(d, use_last && (i == n - 1), lb, t_last, ok);
      if (!ok) all_ok = 0;
      exp_d.push_back(d);
    end
  endtask

  task automatic wait_commit(input int base, input int budget, output bit ok);
    int n = 0;
    ok = 0;
    while (n < budget && !ok) begin
      @(posedge clk);
      #1;
      if (commit_rises > base) ok = 1;
      n++;
    end
  endtask

  // Core side: ack after a delay, then take the buffer for two cycles and free it again.
  task automatic ack_release(input int delay);
    repeat (delay) @(posedge clk);
    #1;
    bus.buf_in_commit_ack = 1'b1;
    @(posedge clk);
    #1;
    bus.buf_in_commit_ack = 1'b0;
    bus.buf_in_ready = 1'b0;
    exp_pkts++;
    idle(2);
    bus.buf_in_ready = 1'b1;
  endtask

  task automatic test_reset();
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready got %b want 0", s_ready); end
    checks++; if (bus.buf_in_wren !== 1'b0) begin errors++; $display("FAIL reset_wren got %b want 0", bus.buf_in_wren); end
    checks++; if (bus.buf_in_commit !== 1'b0) begin errors++; $display("FAIL reset_commit got %b want 0", bus.buf_in_commit); end
    checks++; if (bus.buf_in_addr !== 9'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", bus.buf_in_addr); end
    checks++; if (bus.buf_in_data !== 32'd0) begin errors++; $display("FAIL reset_data got %h want 0", bus.buf_in_data); end
    checks++; if (bus.buf_in_commit_len !== 11'd0) begin errors++; $display("FAIL reset_len got %0d want 0", bus.buf_in_commit_len); end
    checks++; if (pkt_count !== 16'd0) begin errors++; $display("FAIL reset_pkt_count got %0d want 0", pkt_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_backpressure();
    bit seen_ready = 0;
    int wb = wa_q.size();
    int rb;
    bus.buf_in_ready = 1'b0;
    s_data = $urandom(); s_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (s_ready !== 1'b0) seen_ready = 1;
    end
    s_valid = 1'b0;
    checks++; if (seen_ready !== 1'b0) begin errors++; $display("FAIL bp_s_ready got 1 want 0"); end
    checks++; if (wa_q.size() - wb !== 0) begin errors++; $display("FAIL bp_writes got %0d want 0", wa_q.size() - wb); end
    @(posedge clk);
    #1;
    bus.buf_in_ready = 1'b1;
    @(negedge clk);
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_same_cycle got %b want 0", s_ready); end
    @(posedge clk);
    #1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL bp_fill_next_cycle got %b want 1", s_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy got %b want 1", busy); end
    rb = commit_rises;
    idle(3 * TIMEOUT);
    checks++; if (commit_rises !== rb) begin errors++; $display("FAIL empty_no_commit got %0d commits want 0", commit_rises - rb); end
  endtask

  task automatic test_full_packet();
    int  wb = wa_q.size();
    int  rb = commit_rises;
    time t;
    bit  ok;
    exp_d.delete();
    send_pkt(MAXW, 0, 3'd0, 3, 1, t, ok);
    checks++; if (!ok) begin errors++; $display("FAIL full_accept got stall want accepted"); end
    wait_commit(rb, 50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL full_commit got none want commit"); end
    checks++; if (wa_q.size() - wb !== MAXW) begin errors++; $display("FAIL full_nwrites got %0d want %0d", wa_q.size() - wb, MAXW); end
    for (int i = 0; i < exp_d.size() && wb + i < wa_q.size(); i++) begin
      checks++;
      if (wa_q[wb + i] !== i || wd_q[wb + i] !== exp_d[i]) begin
        errors++;
        $display("FAIL full_write got a=%0d d=%h want a=%0d d=%h", wa_q[wb + i], wd_q[wb + i], i, exp_d[i]);
      end
    end
    checks++; if (commit_len_seen !== 11'd1024) begin errors++; $display("FAIL full_len got %0d want 1024", commit_len_seen); end
    checks++; if (overlap !== 0) begin errors++; $display("FAIL full_wren_commit_overlap got %0d want 0", overlap); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL full_s_ready_commit got %b want 0", s_ready); end
    ack_release(5);
    checks++; if (pkt_count !== 16'(exp_pkts)) begin errors++; $display("FAIL full_pkt_count got %0d want %0d", pkt_count, exp_pkts); end
    checks++; if (bus.buf_in_commit !== 1'b0) begin errors++; $display("FAIL full_commit_drop got %b want 0", bus.buf_in_commit); end
  endtask

  task automatic test_short_last();
    int   nw[5];
    logic [2:0] lbs[5];
    nw[0] = 4; lbs[0] = 3'd1;
    for (int k = 1; k < 4; k++) begin nw[k] = $urandom_range(1, 20); lbs[k] = 3'($urandom_range(1, 4)); end
    nw[4] = MAXW; lbs[4] = 3'd2;
    for (int k = 0; k < 5; k++) begin
      int  wb = wa_q.size();
      int  rb = commit_rises;
      int  exp_len = (nw[k] - 1) * 4 + int'(lbs[k]);
      time t;
      bit  ok;
      exp_d.delete();
      send_pkt(nw[k], 1, lbs[k], 2, 0, t, ok);
      wait_commit(rb, 50, ok);
      checks++; if (!ok) begin errors++; $display("FAIL last_commit pkt%0d got none want commit", k); end
      checks++; if (wa_q.size() - wb !== nw[k]) begin errors++; $display("FAIL last_nwrites pkt%0d got %0d want %0d", k, wa_q.size() - wb, nw[k]); end
      for (int i = 0; i < exp_d.size() && wb + i < wa_q.size(); i++) begin
        checks++;
        if (wa_q[wb + i] !== i || wd_q[wb + i] !== exp_d[i]) begin
          errors++;
          $display("FAIL last_write pkt%0d got a=%0d d=%h want a=%0d d=%h", k, wa_q[wb + i], wd_q[wb + i], i, exp_d[i]);
        end
      end
      checks++; if (commit_len_seen !== 11'(exp_len)) begin errors++; $display("FAIL last_len pkt%0d got %0d want %0d", k, commit_len_seen, exp_len); end
      ack_release($urandom_range(0, 4));
      checks++; if (pkt_count !== 16'(exp_pkts)) begin errors++; $display("FAIL last_pkt_count got %0d want %0d", pkt_count, exp_pkts); end
    end
  endtask

  task automatic test_timeout();
    int  wb = wa_q.size();
    int  rb = commit_rises;
    time t;
    bit  ok;
    exp_d.delete();
    send_pkt(5, 0, 3'd0, 2, 0, t, ok);
    wait_commit(rb, 3 * TIMEOUT, ok);
    checks++; if (!ok) begin errors++; $display("FAIL timeout_commit got none want commit"); end
    checks++;
    if (commit_t - t !== time'(TIMEOUT * PERIOD + PERIOD / 2)) begin
      errors++; $display("FAIL timeout_latency got %0t want %0t", commit_t - t, time'(TIMEOUT * PERIOD + PERIOD / 2));
    end
    checks++; if (commit_len_seen !== 11'd20) begin errors++; $display("FAIL timeout_len got %0d want 20", commit_len_seen); end
    checks++; if (wa_q.size() - wb !== 5) begin errors++; $display("FAIL timeout_nwrites got %0d want 5", wa_q.size() - wb); end
    ack_release(2);
    checks++; if (pkt_count !== 16'(exp_pkts)) begin errors++; $display("FAIL timeout_pkt_count got %0d want %0d", pkt_count, exp_pkts); end
  endtask

  task automatic test_back_to_back();
    int  wb = wa_q.size();
    int  rb = commit_rises;
    time t1, t2;
    bit  ok;
    exp_d.delete();
    send_pkt(3, 0, 3'd0, 0, 0, t1, ok);
    idle(TIMEOUT - 1);
    send_pkt(1, 0, 3'd0, 0, 0, t2, ok);
    checks++; if (t2 - t1 !== time'(TIMEOUT * PERIOD)) begin errors++; $display("FAIL simul_accept_time got %0t want %0t", t2 - t1, time'(TIMEOUT * PERIOD)); end
    idle(1);
    checks++; if (commit_rises !== rb) begin errors++; $display("FAIL simul_early_commit got %0d commits want 0", commit_rises - rb); end
    wait_commit(rb, 3 * TIMEOUT, ok);
    checks++; if (!ok) begin errors++; $display("FAIL simul_commit got none want commit"); end
    checks++;
    if (commit_t - t2 !== time'(TIMEOUT * PERIOD + PERIOD / 2)) begin
      errors++; $display("FAIL simul_timer_restart got %0t want %0t", commit_t - t2, time'(TIMEOUT * PERIOD + PERIOD / 2));
    end
    checks++; if (commit_len_seen !== 11'd16) begin errors++; $display("FAIL simul_len got %0d want 16", commit_len_seen); end
    checks++; if (wa_q.size() - wb !== 4) begin errors++; $display("FAIL simul_nwrites got %0d want 4", wa_q.size() - wb); end
    for (int i = 0; i < exp_d.size() && wb + i < wa_q.size(); i++) begin
      checks++;
      if (wa_q[wb + i] !== i || wd_q[wb + i] !== exp_d[i]) begin
        errors++;
        $display("FAIL simul_write got a=%0d d=%h want a=%0d d=%h", wa_q[wb + i], wd_q[wb + i], i, exp_d[i]);
      end
    end
    ack_release(1);
  endtask

  task automatic test_reset_mid_commit();
    int  wb;
    int  rb = commit_rises;
    time t;
    bit  ok;
    exp_d.delete();
    send_pkt(2, 1, 3'd3, 0, 0, t, ok);
    wait_commit(rb, 20, ok);
    checks++; if (bus.buf_in_commit !== 1'b1) begin errors++; $display("FAIL rst_pre_commit got %b want 1", bus.buf_in_commit); end
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bus.buf_in_commit !== 1'b0) begin errors++; $display("FAIL rst_commit_drop got %b want 0", bus.buf_in_commit); end
    checks++; if (bus.buf_in_addr !== 9'd0) begin errors++; $display("FAIL rst_addr got %0d want 0", bus.buf_in_addr); end
    checks++; if (pkt_count !== 16'd0) begin errors++; $display("FAIL rst_pkt_count got %0d want 0", pkt_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    reset = 1'b0;
    exp_pkts = 0;
    wb = wa_q.size();
    rb = commit_rises;
    exp_d.delete();
    send_pkt(3, 1, 3'd4, 1, 0, t, ok);
    wait_commit(rb, 20, ok);
    checks++; if (wa_q.size() - wb !== 3) begin errors++; $display("FAIL rst_nwrites got %0d want 3", wa_q.size() - wb); end
    for (int i = 0; i < exp_d.size() && wb + i < wa_q.size(); i++) begin
      checks++;
      if (wa_q[wb + i] !== i || wd_q[wb + i] !== exp_d[i]) begin
        errors++;
        $display("FAIL rst_write got a=%0d d=%h want a=%0d d=%h", wa_q[wb + i], wd_q[wb + i], i, exp_d[i]);
      end
    end
    checks++; if (commit_len_seen !== 11'd12) begin errors++; $display("FAIL rst_len got %0d want 12", commit_len_seen); end
    ack_release(3);
    checks++; if (pkt_count !== 16'(exp_pkts)) begin errors++; $display("FAIL rst_pkt_count_after got %0d want %0d", pkt_count, exp_pkts); end
  endtask

  initial begin
    reset = 1'b1;
    s_data = '0; s_valid = 1'b0; s_last = 1'b0; s_last_bytes = 3'd0;
    bus.buf_in_ready = 1'b0;
    bus.buf_in_commit_ack = 1'b0;
    idle(3);
    reset = 1'b0;
    test_reset();
    test_backpressure();
    test_full_packet();
    test_short_last();
    test_timeout();
    test_back_to_back();
    test_reset_mid_commit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/usb3_buf_in_streamer.md
Name: usb3_buf_in_streamer

Overview:
- Source-side client of the USB3 core endpoint IN buffer interface (buf_in_*). It is the writer/committer for the buffer that the core reads and transmits.
- Accepts a 32-bit valid/ready word stream from user logic and writes it into the endpoint buffer RAM.
- Commits a packet with its byte length when the packet is full, on stream last, or on idle timeout, then waits for the core's commit acknowledge before filling the next packet.
- Sits beside the USB3 core in the FPGA top, on the endpoint-buffer clock domain.

Parameters:
- ADDR_WIDTH, 9, buffer word-address width (matches buf_in_addr).
- MAX_PKT_WORDS, 256, words per full packet (1024 bytes, SuperSpeed bulk max). Must be ≤ 2^ADDR_WIDTH.
- LEN_WIDTH, 11, byte-length width (matches buf_in_commit_len).
- TIMEOUT_CYCLES, 4096, idle cycles after which a partial packet is committed. 0 disables the timeout.

Ports:
- ext_clk  in  1  sole clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- s_data  in  32  stream word; byte 0 is [7:0].
- s_valid  in  1  stream word valid.
- s_last  in  1  word is the final word of a transfer.
- s_last_bytes  in  3  valid bytes in the last word (1..4); ignored unless s_last.
- s_ready  out  1  streamer accepts the word this cycle.
- buf_in_ready  in  1  core reports the IN buffer is free for writing.
- buf_in_addr  out  ADDR_WIDTH  buffer write address.
- buf_in_data  out  32  buffer write data.
- buf_in_wren  out  1  buffer write strobe.
- buf_in_commit  out  1  commit request, held until acknowledged.
- buf_in_commit_len  out  LEN_WIDTH  committed length in bytes.
- buf_in_commit_ack  in  1  core accepted the commit.
- pkt_count  out  16  packets committed, wraps at 2^16.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset values: s_ready=0, buf_in_wren=0, buf_in_commit=0, buf_in_addr=0, buf_in_data=0, buf_in_commit_len=0, pkt_count=0, busy=0. Internal state IDLE, word count 0, timer 0.
- Reset mid-operation aborts immediately: any pending commit drops the next cycle and partial data is discarded.
- State IDLE:
  - busy=0, s_ready=0.
  - When buf_in_ready=1, go to FILL with word count wcnt=0.
- State FILL:
  - s_ready=1 combinationally.
  - A word is accepted when s_valid && s_ready. Next cycle: buf_in_wren=1, buf_in_addr=wcnt, buf_in_data=s_data. Write latency is exactly 1 cycle.
  - wcnt increments on each accepted word.
  - buf_in_ready deasserting during FILL is ignored; the buffer is owned until commit.
- Commit conditions, evaluated on the accepted word:
  - s_last=1: length = wcnt*4 + s_last_bytes, where wcnt is the value before increment.
  - Otherwise, if wcnt+1 == MAX_PKT_WORDS: length = MAX_PKT_WORDS*4.
  - s_last on the MAX_PKT_WORDS-th word uses the s_last rule.
  - Either condition sends the FSM to COMMIT. s_ready is 0 from the following cycle.
- Timeout:
  - In FILL with wcnt>0, the idle timer counts cycles without an accepted word.
  - On reaching TIMEOUT_CYCLES, go to COMMIT with length = wcnt*4.
  - The timer clears on every accepted word and on entry to FILL.
  - The timeout never fires with wcnt=0; no empty packet is generated.
- Simultaneous accepted word and timeout expiry: the word wins. It is written, the timer clears, and the commit rules above apply.
- State COMMIT:
  - Entered one cycle after the last write. buf_in_commit=1 and buf_in_commit_len held stable.
  - The last buf_in_wren precedes buf_in_commit by at least 1 cycle.
  - On buf_in_commit_ack=1: drop commit the next cycle, increment pkt_count, go to WAIT_FREE.
- State WAIT_FREE:
  - Wait for buf_in_ready=0, meaning the core has taken the buffer, then return to IDLE.
  - If buf_in_ready stays 1 for 2 cycles after ack, also return to IDLE. This covers a core that frees the buffer within one cycle.
- Width rule: the length computation is LEN_WIDTH bits. MAX_PKT_WORDS*4 must fit, which is checked by an elaboration-time assertion.

Decomposition:
- Package usb3_buf_pkg holds:
  - state enum buf_in_state_t {IDLE, FILL, COMMIT, WAIT_FREE};
  - localparam BYTES_PER_WORD=4;
  - the length-computation function.
- One natural sub-module, usb3_idle_timer: a loadable/clearable down-counter with TIMEOUT_CYCLES and a disable-when-0 parameter, producing a 1-cycle expiry pulse.

Test Plan:
- Full packet: buf_in_ready=1, stream 256 words with values 0..255 and no s_last. Expect 256 writes at addr 0..255, then commit_len=1024. Ack after 5 cycles gives pkt_count=1.
- Short last: 3 words, then a 4th with s_last=1 and s_last_bytes=1. Expect 4 writes and commit_len=13.
- Timeout: TIMEOUT_CYCLES=16, 5 words, then s_valid=0. Expect commit exactly 16 cycles after the last accept, with commit_len=20. Also check that 0 words never commits.
- Backpressure: buf_in_ready=0 at start. Expect s_ready=0 and no writes. Raise buf_in_ready, then FILL starts the next cycle.
- Reset mid-commit: assert reset while buf_in_commit=1. Next cycle commit=0, addr=0, pkt_count=0. After release, a new packet writes from addr 0.
- Simultaneous events: a word accepted on the timeout-expiry cycle is written, no early commit occurs, and the timer restarts.
